alu_seq: RTL and testbench

Sequential ALU stage consuming the 16-bit B bus and the accumulator (A) operand and driving the C bus back to the register file. It executes single-cycle arithmetic/shift operations and, optionally, an iterative 16-cycle shift-add multiply used for the down-sampler's weighted-pixel arithmetic. Results and flags are registered; a start/busy/done handshake with the control unit sequences each operation.

---
 rtl/alu_seq.sv | 195 +++++++++++++++++++
 tb/tb_alu_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU stage: single-cycle add/sub/pass/inc/shift with registered result and flags.
// Define ALU_MUL_EN to build the iterative 16-cycle shift-add multiplier for op 6.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       alu_op,
    input  logic             start,
    input  logic [WIDTH-1:0] A_bus,
    input  logic [WIDTH-1:0] B_bus,
    output logic [WIDTH-1:0] C_bus,
    output logic             z_flag,
    output logic             c_flag,
    output logic             busy,
    output logic             done
);
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_PASSB = 3'd3;
    localparam logic [2:0] OP_INCA  = 3'd4;
    localparam logic [2:0] OP_SHR   = 3'd5;
    localparam logic [2:0] OP_MUL   = 3'd6;

    logic [WIDTH-1:0] res_s;
    logic [WIDTH:0]   ext_s;
    logic [3:0]       sh_s;
    logic             cout_s;
    logic             wr_s;

    logic [WIDTH-1:0] c_bus_q, c_bus_d;
    logic             z_flag_q, z_flag_d;
    logic             c_flag_q, c_flag_d;
    logic             done_q, done_d;

    // Single-cycle result and carry straight from the operand buses
    always_comb begin
        res_s  = {WIDTH{1'b0}};
        ext_s  = {(WIDTH+1){1'b0}};
        sh_s   = B_bus[3:0];
        cout_s = 1'b0;
        wr_s   = 1'b1;
        case (alu_op)
            OP_ADD: begin
                ext_s  = {1'b0, A_bus} + {1'b0, B_bus};
                res_s  = ext_s[WIDTH-1:0];
                cout_s = ext_s[WIDTH];
            end
            OP_SUB: begin
                ext_s  = {1'b0, A_bus} - {1'b0, B_bus};
                res_s  = ext_s[WIDTH-1:0];
                cout_s = ext_s[WIDTH];
            end
            OP_PASSB: res_s = B_bus;
            OP_INCA: begin
                ext_s  = {1'b0, A_bus} + {{WIDTH{1'b0}}, 1'b1};
                res_s  = ext_s[WIDTH-1:0];
                cout_s = ext_s[WIDTH];
            end
            OP_SHR: begin
                res_s = A_bus >> sh_s;
                if (sh_s == 4'd0) begin
                    cout_s = 1'b0;
                end else begin
                    cout_s = A_bus[sh_s - 4'd1];
                end
            end
            default: wr_s = 1'b0;
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [WIDTH:0]     acc_s;
    logic [2*WIDTH-1:0] step_s;

    // Low half of prod_q holds the remaining multiplier bits; each step adds into the high half and shifts right
    always_comb begin
        if (prod_q[0]) begin
            acc_s = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        end else begin
            acc_s = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
        end
        step_s = {acc_s, prod_q[WIDTH-1:1]};
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        c_bus_d  = c_bus_q;
        z_flag_d = z_flag_q;
        c_flag_d = c_flag_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (alu_op == OP_MUL)) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    mcand_d = A_bus;
                    prod_d  = {{WIDTH{1'b0}}, B_bus};
                    cnt_d   = 4'd0;
                end else if (start && wr_s) begin
                    done_d   = 1'b1;
                    c_bus_d  = res_s;
                    z_flag_d = (res_s == {WIDTH{1'b0}});
                    c_flag_d = cout_s;
                end else begin
                    done_d = start;
                end
            end
            ST_RUN: begin
                prod_d = step_s;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    c_bus_d  = step_s[WIDTH-1:0];
                    z_flag_d = (step_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    c_flag_d = |step_s[2*WIDTH-1:WIDTH];
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Multiplier state, counter and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mcand_q <= {WIDTH{1'b0}};
            prod_q  <= {(2*WIDTH){1'b0}};
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    // Every accepted op finishes in one cycle; op 6 falls into the hold path with the reserved code
    always_comb begin
        done_d   = 1'b0;
        c_bus_d  = c_bus_q;
        z_flag_d = z_flag_q;
        c_flag_d = c_flag_q;
        if (start && wr_s) begin
            done_d   = 1'b1;
            c_bus_d  = res_s;
            z_flag_d = (res_s == {WIDTH{1'b0}});
            c_flag_d = cout_s;
        end else begin
            done_d = start;
        end
    end

    assign busy = 1'b0;
`endif

    // Result, flag and completion registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_bus_q  <= {WIDTH{1'b0}};
            z_flag_q <= 1'b0;
            c_flag_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            c_bus_q  <= c_bus_d;
            z_flag_q <= z_flag_d;
            c_flag_q <= c_flag_d;
            done_q   <= done_d;
        end
    end

    assign C_bus  = c_bus_q;
    assign z_flag = z_flag_q;
    assign c_flag = c_flag_q;
    assign done   = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; multiply scenarios are built when ALU_MUL_EN is defined.
module tb_alu_seq;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       alu_op;
    logic             start;
    logic [WIDTH-1:0] A_bus;
    logic [WIDTH-1:0] B_bus;
    logic [WIDTH-1:0] C_bus;
    logic             z_flag;
    logic             c_flag;
    logic             busy;
    logic             done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .start(start),
        .A_bus(A_bus), .B_bus(B_bus), .C_bus(C_bus),
        .z_flag(z_flag), .c_flag(c_flag), .busy(busy), .done(done)
    );

    // Presents one op for exactly one rising edge, then scrambles the buses; returns on the following falling edge
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        alu_op = op; A_bus = a; B_bus = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A_bus = 16'hDEAD; B_bus = 16'hBEEF;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; alu_op = 3'd0; A_bus = 16'h0000; B_bus = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (C_bus !== 16'h0000) $display("FAIL reset_c_bus got %h want %h", C_bus, 16'h0000); else pass_cnt++;
        total_cnt++; if (z_flag !== 1'b0) $display("FAIL reset_z got %b want 0", z_flag); else pass_cnt++;
        total_cnt++; if (c_flag !== 1'b0) $display("FAIL reset_c got %b want 0", c_flag); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        rst_n = 1'b1;
        issue(3'd1, 16'hFFFF, 16'h0001);
        total_cnt++; if (C_bus !== 16'h0000) $display("FAIL add_wrap_c_bus got %h want %h", C_bus, 16'h0000); else pass_cnt++;
        total_cnt++; if (z_flag !== 1'b1) $display("FAIL add_wrap_z got %b want 1", z_flag); else pass_cnt++;
        total_cnt++; if (c_flag !== 1'b1) $display("FAIL add_wrap_c got %b want 1", c_flag); else pass_cnt++;
        total_cnt++; if (done !== 1'b1) $display("FAIL add_done got %b want 1", done); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0) $display("FAIL add_done_drop got %b want 0", done); else pass_cnt++;
    endtask

    task automatic test_sub_shr;
        issue(3'd2, 16'd5, 16'd9);
        total_cnt++; if (C_bus !== 16'hFFFC) $display("FAIL sub_c_bus got %h want %h", C_bus, 16'hFFFC); else pass_cnt++;
        total_cnt++; if (c_flag !== 1'b1) $display("FAIL sub_borrow got %b want 1", c_flag); else pass_cnt++;
        total_cnt++; if (z_flag !== 1'b0) $display("FAIL sub_z got %b want 0", z_flag); else pass_cnt++;
        issue(3'd5, 16'h00F3, 16'd4);
        total_cnt++; if (C_bus !== 16'h000F) $display("FAIL shr4_c_bus got %h want %h", C_bus, 16'h000F); else pass_cnt++;
        total_cnt++; if (c_flag !== 1'b0) $display("FAIL shr4_c got %b want 0", c_flag); else pass_cnt++;
        issue(3'd5, 16'h0018, 16'd4);
        total_cnt++; if (C_bus !== 16'h0001) $display("FAIL shr4b_c_bus got %h want %h", C_bus, 16'h0001); else pass_cnt++;
        total_cnt++; if (c_flag !== 1'b1) $display("FAIL shr4b_c got %b want 1", c_flag); else pass_cnt++;
        issue(3'd5, 16'h00F3, 16'd0);
        total_cnt++; if (C_bus !== 16'h00F3) $display("FAIL shr0_c_bus got %h want %h", C_bus, 16'h00F3); else pass_cnt++;
        total_cnt++; if (c_flag !== 1'b0) $display("FAIL shr0_c got %b want 0", c_flag); else pass_cnt++;
    endtask

    task automatic test_pass_inc_hold;
        issue(3'd4, 16'hFFFF, 16'h0000);
        total_cnt++; if (C_bus !== 16'h0000) $display("FAIL inca_wrap_c_bus got %h want %h", C_bus, 16'h0000); else pass_cnt++;
        total_cnt++; if (c_flag !== 1'b1) $display("FAIL inca_wrap_c got %b want 1", c_flag); else pass_cnt++;
        total_cnt++; if (z_flag !== 1'b1) $display("FAIL inca_wrap_z got %b want 1", z_flag); else pass_cnt++;
        issue(3'd3, 16'h5555, 16'h1234);
        total_cnt++; if (C_bus !== 16'h1234) $display("FAIL passb_c_bus got %h want %h", C_bus, 16'h1234); else pass_cnt++;
        total_cnt++; if (c_flag !== 1'b0) $display("FAIL passb_c got %b want 0", c_flag); else pass_cnt++;
        issue(3'd2, 16'd1, 16'd2);
        total_cnt++; if (C_bus !== 16'hFFFF) $display("FAIL sub_neg_c_bus got %h want %h", C_bus, 16'hFFFF); else pass_cnt++;
        issue(3'd0, 16'h0000, 16'h0000);
        total_cnt++; if (done !== 1'b1) $display("FAIL nop_done got %b want 1", done); else pass_cnt++;
        total_cnt++; if (C_bus !== 16'hFFFF) $display("FAIL nop_hold_c_bus got %h want %h", C_bus, 16'hFFFF); else pass_cnt++;
        total_cnt++; if (c_flag !== 1'b1) $display("FAIL nop_hold_c got %b want 1", c_flag); else pass_cnt++;
        issue(3'd7, 16'h0000, 16'h0000);
        total_cnt++; if (done !== 1'b1) $display("FAIL rsv_done got %b want 1", done); else pass_cnt++;
        total_cnt++; if (C_bus !== 16'hFFFF) $display("FAIL rsv_hold_c_bus got %h want %h", C_bus, 16'hFFFF); else pass_cnt++;
        total_cnt++; if (z_flag !== 1'b0) $display("FAIL rsv_hold_z got %b want 0", z_flag); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        alu_op = 3'd1; A_bus = 16'd1; B_bus = 16'd2; start = 1'b1;
        @(negedge clk);
        total_cnt++; if (C_bus !== 16'd3) $display("FAIL b2b_first got %h want %h", C_bus, 16'd3); else pass_cnt++;
        alu_op = 3'd2; A_bus = 16'd10; B_bus = 16'd3;
        @(negedge clk);
        total_cnt++; if (C_bus !== 16'd7) $display("FAIL b2b_second got %h want %h", C_bus, 16'd7); else pass_cnt++;
        total_cnt++; if (done !== 1'b1) $display("FAIL b2b_done got %b want 1", done); else pass_cnt++;
        total_cnt++; if (c_flag !== 1'b0) $display("FAIL b2b_c got %b want 0", c_flag); else pass_cnt++;
        start = 1'b0;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0) $display("FAIL b2b_done_drop got %b want 0", done); else pass_cnt++;
    endtask

    task automatic test_reset_reissue;
        issue(3'd3, 16'h0000, 16'hA5A5);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total_cnt++; if (C_bus !== 16'h0000) $display("FAIL rst2_c_bus got %h want %h", C_bus, 16'h0000); else pass_cnt++;
        rst_n = 1'b1;
        issue(3'd1, 16'd2, 16'd2);
        total_cnt++; if (C_bus !== 16'd4) $display("FAIL rst2_add got %h want %h", C_bus, 16'd4); else pass_cnt++;
    endtask

`ifdef ALU_MUL_EN
    // Observes falling edges until done (bounded), counting busy cycles and any busy/done overlap
    task automatic wait_done(output int busy_n, output int done_n, output bit overlap);
        busy_n = 0; done_n = 0; overlap = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy === 1'b1) busy_n++;
            if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
            if (done === 1'b1) begin
                done_n++;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mul;
        int bn; int dn; bit ov;
        issue(3'd6, 16'd300, 16'd250);
        wait_done(bn, dn, ov);
        total_cnt++; if (dn !== 1) $display("FAIL mul_done_seen got %0d want 1", dn); else pass_cnt++;
        total_cnt++; if (bn !== 16) $display("FAIL mul_busy_cycles got %0d want 16", bn); else pass_cnt++;
        total_cnt++; if (ov !== 1'b0) $display("FAIL mul_overlap got %b want 0", ov); else pass_cnt++;
        total_cnt++; if (C_bus !== 16'h24F8) $display("FAIL mul_c_bus got %h want %h", C_bus, 16'h24F8); else pass_cnt++;
        total_cnt++; if (c_flag !== 1'b1) $display("FAIL mul_c got %b want 1", c_flag); else pass_cnt++;
        issue(3'd6, 16'd0, 16'd1234);
        wait_done(bn, dn, ov);
        total_cnt++; if (C_bus !== 16'h0000) $display("FAIL mul0_c_bus got %h want %h", C_bus, 16'h0000); else pass_cnt++;
        total_cnt++; if (z_flag !== 1'b1) $display("FAIL mul0_z got %b want 1", z_flag); else pass_cnt++;
        total_cnt++; if (c_flag !== 1'b0) $display("FAIL mul0_c got %b want 0", c_flag); else pass_cnt++;
    endtask

    task automatic test_busy_reject;
        int bn; int dn; int extra; bit ov;
        issue(3'd6, 16'd3, 16'd7);
        alu_op = 3'd1; A_bus = 16'd100; B_bus = 16'd200; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(bn, dn, ov);
        total_cnt++; if (dn !== 1) $display("FAIL rej_done_seen got %0d want 1", dn); else pass_cnt++;
        total_cnt++; if (C_bus !== 16'd21) $display("FAIL rej_c_bus got %h want %h", C_bus, 16'd21); else pass_cnt++;
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        total_cnt++; if (extra !== 0) $display("FAIL rej_extra_done got %0d want 0", extra); else pass_cnt++;
        total_cnt++; if (C_bus !== 16'd21) $display("FAIL rej_c_bus_hold got %h want %h", C_bus, 16'd21); else pass_cnt++;
    endtask

    task automatic test_reset_mid_mul;
        int dn;
        issue(3'd6, 16'd300, 16'd250);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total_cnt++; if (C_bus !== 16'h0000) $display("FAIL rstmul_c_bus got %h want %h", C_bus, 16'h0000); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstmul_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL rstmul_done got %b want 0", done); else pass_cnt++;
        total_cnt++; if (c_flag !== 1'b0) $display("FAIL rstmul_c got %b want 0", c_flag); else pass_cnt++;
        rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dn++;
        end
        total_cnt++; if (dn !== 0) $display("FAIL rstmul_stale_activity got %0d want 0", dn); else pass_cnt++;
        issue(3'd1, 16'd2, 16'd2);
        total_cnt++; if (C_bus !== 16'd4) $display("FAIL rstmul_add got %h want %h", C_bus, 16'd4); else pass_cnt++;
    endtask
`else
    task automatic test_mul_disabled;
        issue(3'd2, 16'd1, 16'd2);
        issue(3'd6, 16'd3, 16'd7);
        total_cnt++; if (busy !== 1'b0) $display("FAIL nomul_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b1) $display("FAIL nomul_done got %b want 1", done); else pass_cnt++;
        total_cnt++; if (C_bus !== 16'hFFFF) $display("FAIL nomul_c_bus got %h want %h", C_bus, 16'hFFFF); else pass_cnt++;
        total_cnt++; if (c_flag !== 1'b1) $display("FAIL nomul_c got %b want 1", c_flag); else pass_cnt++;
        total_cnt++; if (z_flag !== 1'b0) $display("FAIL nomul_z got %b want 0", z_flag); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0) $display("FAIL nomul_done_drop got %b want 0", done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL nomul_busy_after got %b want 0", busy); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_sub_shr();
        test_pass_inc_hold();
        test_back_to_back();
        test_reset_reissue();
`ifdef ALU_MUL_EN
        test_mul();
        test_busy_reject();
        test_reset_mid_mul();
`else
        test_mul_disabled();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
